rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Issues a registered one-hot grant and its 3-bit binary index.
- Holds the grant until the winner drops its request, then rotates priority past the winner.
- Sits in front of one-hot-select datapaths; the grant vector drives their enables directly.

Parameters:
- N, 8, number of requesters; fixed at 8 in this revision, and only 8 is supported.
- IDXW, 3, width of the grant index; must equal clog2(N).
- TIMEOUT, 16, maximum number of consecutive cycles one grant may be held; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk, input, 1, rising-edge clock, the only clock.
- rst, input, 1, synchronous reset, active-high.
- req, input, 8, request vector; bit i = requester i wants the resource. Must stay high for as long as the grant is wanted.
- grant, output, 8, registered grant; one-hot or all-zero.
- grant_idx, output, 3, binary index of the set grant bit; 0 when grant_valid=0.
- grant_valid, output, 1, high exactly when grant is nonzero.
- timeout_pulse, output, 1, one-cycle pulse on a forced release; tied to 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (rst=1 at a rising edge):
  - grant=0, grant_idx=0, grant_valid=0, timeout_pulse=0.
  - State = IDLE; priority pointer ptr=0; hold counter=0.
  - Reset during an active grant drops the grant at that same edge.
- States: IDLE (no grant) and BUSY (grant held); 1-bit encoding, IDLE=0.
- Winner selection:
  - Scan from ptr upward with wrap-around (ptr, ptr+1, ..., 7, 0, ..., ptr-1).
  - The first set req bit wins.
  - Selection is combinational; the grant is registered.
- IDLE:
  - If req!=0 in cycle t, grant the winner at edge t+1 and go to BUSY. Latency is one cycle.
  - If req==0, stay in IDLE with all outputs 0.
- BUSY:
  - While req[grant_idx]=1, hold grant, grant_idx and grant_valid unchanged.
  - Changes on other req bits are ignored.
- Release, when req[grant_idx]=0 in cycle t:
  - ptr <= grant_idx+1, modulo 8, wrapping 7 to 0.
  - If any other req bit is set, switch at edge t+1 directly to the new winner, scanning from grant_idx+1. There is no idle bubble. Grant moves one-hot to one-hot and never has two bits set.
  - Otherwise grant goes to 0 at t+1 and the state returns to IDLE.
- Re-request: a requester that releases and re-requests in the very next cycle loses to any other pending requester. It wins only if it is the sole requester.
- Fairness: every persistent requester is granted within 7 grant tenures.
- Invariants, checked every cycle:
  - grant == one-hot decode of grant_idx when grant_valid=1.
  - grant == 0 when grant_valid=0.
  - popcount(grant) <= 1.
- No input may cause X on any output. A req bit that rises and falls while another requester holds the grant is lost.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter increments on every BUSY cycle and clears on any new grant.
  - When the counter reaches TIMEOUT-1 while req[grant_idx] is still 1, treat it as a release, even though req is high.
  - timeout_pulse=1 for the cycle in which the new grant (or idle state) appears.
  - The offender has the lowest priority next round.
- Undefined:
  - No counter logic is built.
  - timeout_pulse is tied to 0.
  - Grants are held indefinitely.

Decomposition:
- Shared package/header:
  - N and IDXW constants.
  - State encodings ST_IDLE and ST_BUSY.
  - TIMEOUT default.
- Sub-module rr_idx_to_onehot (3-to-8 one-hot decode):
  - Builds grant from the next-state index so both outputs come from one source.
  - Fully combinational, with a default branch so nothing is latched.
- Priority scan stays inside rr_grant_arbiter.

Test Plan:
- Reset → requests: hold rst=1 with req=8'hFF → all outputs 0. Release rst → grant=8'h01, idx=0 one cycle later.
- Single requester: req=8'b0001_0000 from IDLE → grant=8'h10, idx=4 after 1 cycle. Drop req → grant=0 next cycle, then ptr=5 for the next arbitration.
- Rotation: req=8'hFF held, each winner drops for 1 cycle then re-raises → grant sequence 01,02,04,...,80,01. No bubble and never two bits set.
- Wrap: ptr=7 with req=8'b1000_0001 → idx 7 granted first; after its release → idx 0 with no gap.
- Reset mid-grant: while grant=8'h08, assert rst → grant=0 at that edge. After release of rst with req=8'h0A → grant=8'h02 (ptr back to 0).
- ARB_TIMEOUT_EN, TIMEOUT=4: req=8'h03 held constantly → idx 0 for 4 cycles, then timeout_pulse=1 with grant=8'h02, then idx 1 for 4 cycles, alternating. Without the macro → idx 0 is held indefinitely and timeout_pulse stays 0.

Source files
------------

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared constants and state encoding for the 8-way round-robin grant arbiter.
package rr_grant_arbiter_pkg;

    localparam int N               = 8;
    localparam int IDXW            = $clog2(N);
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if
    import rr_grant_arbiter_pkg::*;
();

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            grant_valid;
    logic            timeout_pulse;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout_pulse
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout_pulse
    );

endinterface

// File: rtl/rr_grant_arbiter_idx_to_onehot.sv
// 3-to-8 one-hot decoder; an all-zero vector is produced when i_en is low.
module rr_idx_to_onehot
    import rr_grant_arbiter_pkg::*;
(
    input  logic [IDXW-1:0] i_idx,
    input  logic            i_en,
    output logic [N-1:0]    o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            case (i_idx)
                3'd0:    o_onehot = 8'b0000_0001;
                3'd1:    o_onehot = 8'b0000_0010;
                3'd2:    o_onehot = 8'b0000_0100;
                3'd3:    o_onehot = 8'b0000_1000;
                3'd4:    o_onehot = 8'b0001_0000;
                3'd5:    o_onehot = 8'b0010_0000;
                3'd6:    o_onehot = 8'b0100_0000;
                3'd7:    o_onehot = 8'b1000_0000;
                default: o_onehot = '0;
            endcase
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and index.
// Define ARB_TIMEOUT_EN to force a release after TIMEOUT consecutive held cycles.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    rr_grant_arbiter_if.slave bus
);

    state_t          r_state;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] r_grantIdx;
    logic [N-1:0]    r_grant;
    logic            r_grantValid;
    logic            r_timeoutPulse;

    logic            w_timeoutHit;
    logic            w_release;
    logic [IDXW-1:0] w_scanBase;
    logic            w_found;
    logic [IDXW-1:0] w_winIdx;
    logic            w_nextValid;
    logic [IDXW-1:0] w_nextIdx;
    logic            w_newGrant;
    logic [N-1:0]    w_nextGrant;

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] r_holdCnt;

    assign w_timeoutHit = (r_state == ST_BUSY) && bus.req[r_grantIdx]
                          && (r_holdCnt == CNTW'(TIMEOUT - 1));
`else
    assign w_timeoutHit = 1'b0;
`endif

    // On release the scan starts just past the holder, which is also the new pointer.
    assign w_release  = (r_state == ST_BUSY) && (!bus.req[r_grantIdx] || w_timeoutHit);
    assign w_scanBase = (r_state == ST_BUSY) ? r_grantIdx + IDXW'(1) : r_ptr;

    always_comb begin : scan
        logic [IDXW-1:0] cand;
        cand     = '0;
        w_found  = 1'b0;
        w_winIdx = '0;
        for (int k = 0; k < N; k++) begin
            cand = w_scanBase + IDXW'(k);
            if (!w_found && bus.req[cand]) begin
                w_found  = 1'b1;
                w_winIdx = cand;
            end
        end
    end

    always_comb begin
        w_nextValid = r_grantValid;
        w_nextIdx   = r_grantIdx;
        w_newGrant  = 1'b0;
        if ((r_state == ST_IDLE) || w_release) begin
            w_nextValid = w_found;
            w_nextIdx   = w_found ? w_winIdx : '0;
            w_newGrant  = w_found;
        end
    end

    rr_idx_to_onehot u_decode (
        .i_idx    (w_nextIdx),
        .i_en     (w_nextValid),
        .o_onehot (w_nextGrant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_grant        <= '0;
            r_grantIdx     <= '0;
            r_grantValid   <= 1'b0;
            r_timeoutPulse <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_holdCnt      <= '0;
`endif
        end else begin
            r_state        <= w_nextValid ? ST_BUSY : ST_IDLE;
            r_grant        <= w_nextGrant;
            r_grantIdx     <= w_nextIdx;
            r_grantValid   <= w_nextValid;
            r_timeoutPulse <= w_timeoutHit;
            if (w_release) begin
                r_ptr <= r_grantIdx + IDXW'(1);
            end
`ifdef ARB_TIMEOUT_EN
            if (w_newGrant || !w_nextValid) begin
                r_holdCnt <= '0;
            end else if (r_state == ST_BUSY) begin
                r_holdCnt <= r_holdCnt + CNTW'(1);
            end
`endif
        end
    end

    assign bus.grant         = r_grant;
    assign bus.grant_idx     = r_grantIdx;
    assign bus.grant_valid   = r_grantValid;
    assign bus.timeout_pulse = r_timeoutPulse;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: randomized and directed requests vs a holder/pointer model.
module tb_rr_grant_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif
    localparam int TMO = 4;

    logic clk;
    logic rst;

    rr_grant_arbiter_if bus ();

`ifdef ARB_TIMEOUT_EN
    rr_grant_arbiter #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    rr_grant_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       pulse;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who holds the resource, where the next scan starts, how long it has been held.
    int mHolder = -1;
    int mPtr    = 0;
    int mCnt    = 0;

    function automatic int scanFrom(input int start, input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic r, input logic [7:0] q);
        exp_t e;
        logic p;
        p = 1'b0;
        if (r) begin
            mHolder = -1;
            mPtr    = 0;
            mCnt    = 0;
        end else if (mHolder < 0) begin
            mHolder = scanFrom(mPtr, q);
            mCnt    = 0;
        end else if (!q[mHolder] || (TO_EN == 1 && mCnt == TMO - 1)) begin
            p       = (TO_EN == 1) && q[mHolder];
            mPtr    = (mHolder + 1) % 8;
            mHolder = scanFrom(mPtr, q);
            mCnt    = 0;
        end else begin
            mCnt++;
        end
        e.grant = (mHolder >= 0) ? 8'(1 << mHolder) : 8'h00;
        e.idx   = (mHolder >= 0) ? 3'(mHolder) : 3'd0;
        e.valid = (mHolder >= 0);
        e.pulse = p;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] q);
        @(negedge clk);
        rst     = r;
        bus.req = q;
        modelStep(r, q);
    endtask

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("grant", 32'(bus.grant), 32'(e.grant));
        compareField("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
        compareField("grant_valid", 32'(bus.grant_valid), 32'(e.valid));
        compareField("timeout_pulse", 32'(bus.timeout_pulse), 32'(e.pulse));
        compareField("popcount_le1", 32'($countones(bus.grant) <= 1), 32'(1));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] cur;
        rst     = 1'b1;
        bus.req = 8'h00;

        // Reset with all requests high, then release.
        repeat (3) applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b0, 8'hFF);
        applyStimulus(1'b0, 8'hFF);

        // Rotation: each holder drops for one cycle, then re-raises.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 8'hFF & ~8'(1 << mHolder));
            applyStimulus(1'b0, 8'hFF);
        end

        // Single requester, then pointer check.
        applyStimulus(1'b1, 8'h00);
        repeat (3) applyStimulus(1'b0, 8'h10);
        repeat (2) applyStimulus(1'b0, 8'h00);
        repeat (2) applyStimulus(1'b0, 8'h21);
        applyStimulus(1'b0, 8'h00);

        // Wrap from pointer 7 to 0.
        applyStimulus(1'b1, 8'h00);
        repeat (2) applyStimulus(1'b0, 8'h40);
        applyStimulus(1'b0, 8'h00);
        repeat (2) applyStimulus(1'b0, 8'h81);
        repeat (2) applyStimulus(1'b0, 8'h01);
        applyStimulus(1'b0, 8'h00);

        // Reset in the middle of a grant.
        applyStimulus(1'b1, 8'h00);
        repeat (2) applyStimulus(1'b0, 8'h08);
        applyStimulus(1'b1, 8'h08);
        repeat (2) applyStimulus(1'b0, 8'h0A);

        // Two persistent requesters: alternates on timeout when enabled, else held.
        applyStimulus(1'b1, 8'h00);
        repeat (20) applyStimulus(1'b0, 8'h03);

        // Randomized traffic with occasional holder drops and rare resets.
        applyStimulus(1'b1, 8'h00);
        cur = 8'h00;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            end
            if (mHolder >= 0 && $urandom_range(0, 7) == 0) cur[mHolder] = 1'b0;
            applyStimulus(($urandom_range(0, 99) == 0), cur);
        end

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
